cache_pmem_arbiter: RTL and testbench

//   Shares the single physical-memory port between the instruction-cache line fill path
//   and the data-cache line fill/writeback path; the pipelined core issues on both at once.
//   Two-requester, one-grant FSM; forwards one full-line transaction at a time.

---
 rtl/cache_pmem_arbiter.sv | 123 ++++++++++++
 tb/tb_cache_pmem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_pmem_arbiter.sv
// Two-requester arbiter sharing one physical-memory port between the icache fill path
// and the dcache fill/writeback path, one full-line transaction at a time.
`timescale 1ns/1ps

module cache_pmem_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int D_PRIORITY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  localparam bit DP = (D_PRIORITY != 0);

  state_t                r_state;
  logic                  r_last_d;
  logic [LINE_WIDTH-1:0] r_i_rdata;
  logic                  r_i_resp;
  logic [LINE_WIDTH-1:0] r_d_rdata;
  logic                  r_d_resp;
  logic                  r_pmem_read;
  logic                  r_pmem_write;
  logic [ADDR_WIDTH-1:0] r_pmem_address;
  logic [LINE_WIDTH-1:0] r_pmem_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;
  // On a tie, D wins under priority mode, otherwise whoever was not granted last.
  assign w_grant_d = w_d_req && (!w_i_req || DP || !r_last_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the wide rdata/wdata registers are reset too, since the outputs must read 0 in reset.
      r_state        <= IDLE;
      r_last_d       <= 1'b0;
      r_i_rdata      <= '0;
      r_i_resp       <= 1'b0;
      r_d_rdata      <= '0;
      r_d_resp       <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the case overrides them.
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_i_req || w_d_req) begin
            r_last_d <= w_grant_d;
            if (w_grant_d) begin
              r_pmem_address <= d_address;
              r_pmem_wdata   <= d_wdata;
              r_pmem_write   <= d_write;
              r_pmem_read    <= !d_write;
              r_state        <= SERVE_D;
            end else begin
              r_pmem_address <= i_address;
              r_pmem_read    <= 1'b1;
              r_pmem_write   <= 1'b0;
              r_state        <= SERVE_I;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_state      <= DONE;
            if (r_state == SERVE_I) begin
              r_i_resp  <= 1'b1;
              r_i_rdata <= pmem_rdata;
            end else begin
              r_d_resp <= 1'b1;
              if (r_pmem_read) r_d_rdata <= pmem_rdata;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_rdata      = r_i_rdata;
  assign i_resp       = r_i_resp;
  assign d_rdata      = r_d_rdata;
  assign d_resp       = r_d_resp;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

  // Simultaneous dcache read and write is treated as a write but is never expected.
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(d_read && d_write));
  a_resp_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(r_i_resp && r_d_resp));
  a_strobe_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(r_pmem_read && r_pmem_write));

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Bench for cache_pmem_arbiter: one priority instance and one round-robin instance driven
// by directed and random requester/pmem traffic, checked against a transaction-level model.
`timescale 1ns/1ps

module tb_cache_pmem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset_n;

  logic          i_read       [2];
  logic [AW-1:0] i_address    [2];
  logic [LW-1:0] i_rdata      [2];
  logic          i_resp       [2];
  logic          d_read       [2];
  logic          d_write      [2];
  logic [AW-1:0] d_address    [2];
  logic [LW-1:0] d_wdata      [2];
  logic [LW-1:0] d_rdata      [2];
  logic          d_resp       [2];
  logic          pmem_read    [2];
  logic          pmem_write   [2];
  logic [AW-1:0] pmem_address [2];
  logic [LW-1:0] pmem_wdata   [2];
  logic [LW-1:0] pmem_rdata   [2];
  logic          pmem_resp    [2];

  always #5 clk = ~clk;

  // Unit 0: dcache priority on ties. Unit 1: round-robin on ties.
  for (genvar u = 0; u < 2; u++) begin : g_dut
    cache_pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .D_PRIORITY(u == 0 ? 1 : 0)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_read       (i_read[u]),
      .i_address    (i_address[u]),
      .i_rdata      (i_rdata[u]),
      .i_resp       (i_resp[u]),
      .d_read       (d_read[u]),
      .d_write      (d_write[u]),
      .d_address    (d_address[u]),
      .d_wdata      (d_wdata[u]),
      .d_rdata      (d_rdata[u]),
      .d_resp       (d_resp[u]),
      .pmem_read    (pmem_read[u]),
      .pmem_write   (pmem_write[u]),
      .pmem_address (pmem_address[u]),
      .pmem_wdata   (pmem_wdata[u]),
      .pmem_rdata   (pmem_rdata[u]),
      .pmem_resp    (pmem_resp[u])
    );
  end

  // Transaction-level model: who holds the port, what it asked for, when the port frees up.
  bit            act       [2];
  bit            act_wr    [2];
  int            who       [2];
  int            last      [2];
  int            free_edge [2];
  int            lat       [2];
  int            cnt       [2];
  logic [AW-1:0] act_addr  [2];
  logic [LW-1:0] act_wd    [2];
  logic [LW-1:0] exp_i_rd  [2];
  logic [LW-1:0] exp_d_rd  [2];
  int            k;
  int            lat_fixed;
  bit            use_fixed;
  logic [LW-1:0] fixed_rd;
  int            gcnt      [2];
  int            cur       [2];
  int            g_who     [2][64];
  int            g_edge    [2][64];
  int            r_edge    [2][64];
  int            strobe_cnt[2];
  bit            overlap;
  int            n_checks;
  int            n_pass;
  int            n_fail;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      act[u] = 0; act_wr[u] = 0; last[u] = 0; free_edge[u] = 0; cnt[u] = 0; lat[u] = 0;
      exp_i_rd[u] = '0; exp_d_rd[u] = '0;
      i_read[u] = 0; d_read[u] = 0; d_write[u] = 0; pmem_resp[u] = 0;
      i_address[u] = '0; d_address[u] = '0; d_wdata[u] = '0; pmem_rdata[u] = '0;
    end
  endtask

  task automatic clear_log();
    for (int u = 0; u < 2; u++) begin
      gcnt[u] = 0;
      for (int j = 0; j < 64; j++) begin g_who[u][j] = -1; g_edge[u][j] = -100; r_edge[u][j] = 0; end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s u%0d pmem_read", tag, u), LW'(pmem_read[u]), '0);
      check($sformatf("%s u%0d pmem_write", tag, u), LW'(pmem_write[u]), '0);
      check($sformatf("%s u%0d pmem_address", tag, u), LW'(pmem_address[u]), '0);
      check($sformatf("%s u%0d pmem_wdata", tag, u), pmem_wdata[u], '0);
      check($sformatf("%s u%0d i_resp", tag, u), LW'(i_resp[u]), '0);
      check($sformatf("%s u%0d d_resp", tag, u), LW'(d_resp[u]), '0);
      check($sformatf("%s u%0d i_rdata", tag, u), i_rdata[u], '0);
      check($sformatf("%s u%0d d_rdata", tag, u), d_rdata[u], '0);
    end
  endtask

  // One clock: inputs set at the negedge are sampled at the posedge, outputs checked at the next negedge.
  task automatic cycle();
    bit            s_i [2];
    bit            s_d [2];
    bit            s_w [2];
    bit            s_r [2];
    logic [AW-1:0] s_ia[2];
    logic [AW-1:0] s_da[2];
    logic [LW-1:0] s_wd[2];
    logic [LW-1:0] s_rd[2];
    for (int u = 0; u < 2; u++) begin
      s_i[u] = i_read[u]; s_d[u] = d_read[u] | d_write[u]; s_w[u] = d_write[u];
      s_r[u] = pmem_resp[u]; s_ia[u] = i_address[u]; s_da[u] = d_address[u];
      s_wd[u] = d_wdata[u]; s_rd[u] = pmem_rdata[u];
    end
    @(posedge clk);
    @(negedge clk);
    k++;
    for (int u = 0; u < 2; u++) begin
      bit e_ir;
      bit e_dr;
      int g;
      e_ir = 0;
      e_dr = 0;
      if (act[u] && s_r[u]) begin
        act[u] = 0;
        free_edge[u] = k + 2;
        if (cur[u] < 64) r_edge[u][cur[u]] = k;
        if (who[u] == 0) begin
          e_ir = 1;
          exp_i_rd[u] = s_rd[u];
        end else begin
          e_dr = 1;
          if (!act_wr[u]) exp_d_rd[u] = s_rd[u];
        end
      end else if (!act[u] && k >= free_edge[u] && (s_i[u] || s_d[u])) begin
        if (s_i[u] && s_d[u]) g = (u == 0) ? 1 : 1 - last[u];
        else g = s_d[u] ? 1 : 0;
        act[u] = 1; who[u] = g; last[u] = g;
        act_wr[u] = (g == 1) && s_w[u];
        act_addr[u] = (g == 1) ? s_da[u] : s_ia[u];
        act_wd[u] = s_wd[u];
        cnt[u] = 0;
        lat[u] = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
        cur[u] = gcnt[u];
        if (gcnt[u] < 64) begin g_who[u][gcnt[u]] = g; g_edge[u][gcnt[u]] = k; end
        gcnt[u]++;
      end
      check($sformatf("u%0d k%0d pmem_read", u, k), LW'(pmem_read[u]), LW'(act[u] && !act_wr[u]));
      check($sformatf("u%0d k%0d pmem_write", u, k), LW'(pmem_write[u]), LW'(act[u] && act_wr[u]));
      if (act[u]) begin
        check($sformatf("u%0d k%0d pmem_address", u, k), LW'(pmem_address[u]), LW'(act_addr[u]));
        if (act_wr[u]) check($sformatf("u%0d k%0d pmem_wdata", u, k), pmem_wdata[u], act_wd[u]);
      end
      check($sformatf("u%0d k%0d i_resp", u, k), LW'(i_resp[u]), LW'(e_ir));
      check($sformatf("u%0d k%0d d_resp", u, k), LW'(d_resp[u]), LW'(e_dr));
      check($sformatf("u%0d k%0d i_rdata", u, k), i_rdata[u], exp_i_rd[u]);
      check($sformatf("u%0d k%0d d_rdata", u, k), d_rdata[u], exp_d_rd[u]);
      if (i_resp[u] && d_resp[u]) overlap = 1;
      if (pmem_read[u] || pmem_write[u]) strobe_cnt[u]++;
      // Physical memory: answer after the chosen number of strobe cycles.
      pmem_resp[u] = 1'b0;
      pmem_rdata[u] = rand_line();
      if (act[u]) begin
        cnt[u]++;
        if (cnt[u] == lat[u]) begin
          pmem_resp[u] = 1'b1;
          if (use_fixed) pmem_rdata[u] = fixed_rd;
        end
      end
      // Requesters drop their request in the cycle they see their resp.
      if (i_resp[u]) i_read[u] = 1'b0;
      if (d_resp[u]) begin d_read[u] = 1'b0; d_write[u] = 1'b0; end
    end
  endtask

  task automatic drain();
    bit busy;
    busy = 1;
    for (int t = 0; t < 300; t++) begin
      busy = 0;
      for (int u = 0; u < 2; u++) if (i_read[u] || d_read[u] || d_write[u] || act[u]) busy = 1;
      if (!busy) break;
      cycle();
    end
    check("drain_timeout", LW'(busy), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    k = 0; lat_fixed = 0; use_fixed = 0; fixed_rd = '0; overlap = 0;
    for (int u = 0; u < 2; u++) begin strobe_cnt[u] = 0; cur[u] = 0; end
    clear_log();
    model_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Lone icache read, 5-cycle memory, pattern A5.
    lat_fixed = 5; use_fixed = 1; fixed_rd = {32{8'hA5}};
    for (int u = 0; u < 2; u++) begin strobe_cnt[u] = 0; i_read[u] = 1; i_address[u] = 32'h0000_0100; end
    drain();
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d ird_strobe_cycles", u), LW'(strobe_cnt[u]), LW'(5));
      check($sformatf("u%0d ird_rdata", u), i_rdata[u], {32{8'hA5}});
    end

    // Lone dcache writeback, 3-cycle memory; d_rdata stays at its reset value.
    lat_fixed = 3; use_fixed = 0;
    for (int u = 0; u < 2; u++) begin
      strobe_cnt[u] = 0; d_write[u] = 1; d_address[u] = 32'h0000_2000; d_wdata[u] = {16{16'h1234}};
    end
    drain();
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d dwr_strobe_cycles", u), LW'(strobe_cnt[u]), LW'(3));
      check($sformatf("u%0d dwr_d_rdata_kept", u), d_rdata[u], '0);
    end

    // Simultaneous requests: priority unit serves D first; round-robin unit last granted D.
    lat_fixed = 4; overlap = 0;
    clear_log();
    for (int u = 0; u < 2; u++) begin
      i_read[u] = 1; i_address[u] = 32'h0000_0140; d_read[u] = 1; d_address[u] = 32'h0000_0180;
    end
    drain();
    check("u0 tie_first", LW'(g_who[0][0]), LW'(1));
    check("u0 tie_second", LW'(g_who[0][1]), LW'(0));
    check("u0 tie_gap", LW'(g_edge[0][1] - r_edge[0][0]), LW'(2));
    check("u1 tie_first", LW'(g_who[1][0]), LW'(0));
    check("u1 tie_second", LW'(g_who[1][1]), LW'(1));
    check("tie_resp_overlap", LW'(overlap), '0);

    // Reset in the middle of a long dcache writeback.
    lat_fixed = 40;
    for (int u = 0; u < 2; u++) begin d_write[u] = 1; d_address[u] = 32'h0000_7000; d_wdata[u] = rand_line(); end
    repeat (4) cycle();
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    repeat (10) cycle();

    // Continuous contention after reset: priority unit always D, round-robin alternates from D.
    lat_fixed = 2;
    clear_log();
    for (int u = 0; u < 2; u++) begin
      i_read[u] = 1; i_address[u] = 32'h0000_3000; d_read[u] = 1; d_address[u] = 32'h0000_4000;
    end
    for (int t = 0; t < 200; t++) begin
      cycle();
      for (int u = 0; u < 2; u++) begin
        if (!i_read[u] && !i_resp[u] && gcnt[u] < 4) i_read[u] = 1;
        if (!d_read[u] && !d_resp[u] && gcnt[u] < 4) d_read[u] = 1;
      end
      if (gcnt[0] >= 4 && gcnt[1] >= 4) break;
    end
    drain();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("u0 contention_grant%0d", j), LW'(g_who[0][j]), LW'(1));
      check($sformatf("u1 contention_grant%0d", j), LW'(g_who[1][j]), LW'((j % 2 == 0) ? 1 : 0));
    end

    // dcache read arriving while the icache is being served waits for IDLE.
    lat_fixed = 6;
    clear_log();
    for (int u = 0; u < 2; u++) begin i_read[u] = 1; i_address[u] = 32'h0000_5000; end
    repeat (3) cycle();
    for (int u = 0; u < 2; u++) begin d_read[u] = 1; d_address[u] = 32'h0000_6000; end
    drain();
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d pend_first", u), LW'(g_who[u][0]), LW'(0));
      check($sformatf("u%0d pend_second", u), LW'(g_who[u][1]), LW'(1));
      check($sformatf("u%0d pend_gap", u), LW'(g_edge[u][1] - r_edge[u][0]), LW'(2));
    end

    // Random traffic with random memory latency and address changes while waiting.
    lat_fixed = 0;
    clear_log();
    overlap = 0;
    for (int t = 0; t < 800; t++) begin
      cycle();
      for (int u = 0; u < 2; u++) begin
        if (!i_read[u] && !i_resp[u]) begin
          if ($urandom_range(0, 3) == 0) begin i_read[u] = 1; i_address[u] = $urandom & 32'hFFFF_FFE0; end
        end else if (i_read[u] && !(act[u] && who[u] == 0) && $urandom_range(0, 7) == 0) begin
          i_address[u] = $urandom & 32'hFFFF_FFE0;
        end
        if (!d_read[u] && !d_write[u] && !d_resp[u]) begin
          if ($urandom_range(0, 3) == 0) begin
            d_write[u] = 1'($urandom_range(0, 1));
            d_read[u] = !d_write[u];
            d_address[u] = $urandom & 32'hFFFF_FFE0;
            d_wdata[u] = rand_line();
          end
        end else if ((d_read[u] || d_write[u]) && !(act[u] && who[u] == 1) && $urandom_range(0, 7) == 0) begin
          d_address[u] = $urandom & 32'hFFFF_FFE0;
          d_wdata[u] = rand_line();
        end
      end
    end
    drain();
    check("random_resp_overlap", LW'(overlap), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
